mem_stage_ws: RTL and testbench
===============================

MEM_STAGE_WS -- requirements
Module: mem_stage_ws

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: data memory holds 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, range 0..7: extra cycles per memory access.
REQ-003 clk  input  1  the only clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream holds a valid EX/MEM bundle.
REQ-006 in_ready  output  1  stage accepts the bundle this cycle.
REQ-007 mem_read, mem_write  input  1 each  load / store request.
REQ-008 mem_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 mem_signed  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 alu_result, write_data, pc_plus4  input  32 each  byte address, store data, link value.
REQ-011 memto_reg  input  2; reg_write  input  1; write_reg  input  5  writeback control, passed through.
REQ-012 flush  input  1  kill the accepted or waiting operation.
REQ-013 wb_valid  output  1; wb_ready  input  1  MEM/WB handshake.
REQ-014 wb_alu_result, wb_read_data, wb_pc_plus4  output  32 each; wb_memto_reg  output  2; wb_reg_write  output  1; wb_write_reg  output  5  registered MEM/WB bundle.
REQ-015 misalign  output  1  present only with MEM_STAGE_ALIGN_CHECK_EN.

Function
REQ-016 Accept happens when in_valid & in_ready & ~flush; in_ready = (state==IDLE) & (~wb_valid | wb_ready).
REQ-017 States are IDLE and WAIT; IDLE->WAIT on an accepted memory op when WAIT_STATES>0; WAIT->IDLE after WAIT_STATES cycles, or on flush.
REQ-018 A non-memory op, or any op when WAIT_STATES=0, loads the MEM/WB register on the accept edge, giving 1-cycle latency; a memory op completes WAIT_STATES+1 cycles after accept.
REQ-019 While in WAIT, in_ready stays 0 and the captured bundle is held internally, independent of the upstream inputs.
REQ-020 Word index = alu_result[DEPTH_LOG2+1:2]; when any alu_result[31:DEPTH_LOG2+2] bit is set, the store is dropped and the load returns 0.
REQ-021 Byte lanes are little-endian: a byte store writes only lane alu_result[1:0], a halfword store writes only lane pair alu_result[1]; other lanes are unchanged.
REQ-022 A load returns the selected byte/halfword right-aligned, extended per mem_signed; a word load returns the whole word.
REQ-023 A store writes memory only on its completion edge; wb_read_data = 0 for stores and non-memory ops.
REQ-024 When mem_read and mem_write are both 1, the op is a store.
REQ-025 A flush in WAIT aborts the op without a memory write or a wb update; a flush has no effect on an already-valid wb register.
REQ-026 wb_valid sets on completion, stays set with the bundle stable until the cycle wb_ready=1, and is then cleared unless a new completion occurs on the same edge.
REQ-027 A load issued directly after a store to the same word returns the stored data.

Reset
REQ-028 When reset=1 at a clock edge: state=IDLE, wait counter=0, wb_valid=0, all wb_* outputs=0, misalign=0; in_ready is 1 in the following cycle.
REQ-029 Reset asserted in WAIT aborts the op, with no memory write; memory contents are not cleared by reset.

Configuration
REQ-030 With MEM_STAGE_ALIGN_CHECK_EN defined, a halfword op with alu_result[0]=1 or a word op with alu_result[1:0]!=0 completes with no memory write, wb_read_data=0, wb_reg_write=0, and a 1-cycle misalign pulse on the completion edge.
REQ-031 Without MEM_STAGE_ALIGN_CHECK_EN there is no misalign port, and the low address bits are ignored for word and halfword alignment, which accesses the aligned containing unit.

Verification
REQ-032 WAIT_STATES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> wb_read_data=0xDEADBEEF two cycles after the load is accepted; in_ready low for one cycle per op.
REQ-033 Store byte 0x80 @0x13 over 0x00000000, then load signed byte @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x10 -> 0x80000000.
REQ-034 wb_ready=0 for 3 cycles with wb_valid=1 -> wb bundle stable, in_ready=0; wb_ready=1 with a new op pending -> back-to-back completions with no bubble.
REQ-035 Store 0x1234 accepted, flush asserted during WAIT -> no wb_valid, and a later load of that address returns the old value.
REQ-036 Load @0x00010000 with DEPTH_LOG2=8 -> wb_read_data=0; store there -> memory unchanged.
REQ-037 With the macro defined, halfword load @0x21 -> misalign=1 for 1 cycle and wb_reg_write=0; reset during WAIT -> wb_valid=0 and in_ready=1 next cycle.

Source files
------------

// File: rtl/mem_stage_ws.sv
// ============================================================================
// Module   : mem_stage_ws
// Brief    : Pipeline MEM stage with wait-stated data memory and MEM/WB reg.
//            Optional alignment check via `define MEM_STAGE_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ws #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  memto_reg,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_pc_plus4,
    output logic [1:0]  wb_memto_reg,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam logic       c_ST_IDLE = 1'b0;
    localparam logic       c_ST_WAIT = 1'b1;
    localparam logic [2:0] c_WS      = 3'(WAIT_STATES);
    localparam int         c_WORDS   = 1 << DEPTH_LOG2;

    logic        r_state, w_state_nxt;
    logic [2:0]  r_cnt;
    logic [31:0] r_mem [c_WORDS];

    logic        r_op_read, r_op_write, r_op_signed, r_op_regwr;
    logic [1:0]  r_op_size, r_op_memto;
    logic [31:0] r_op_addr, r_op_wdata, r_op_pc4;
    logic [4:0]  r_op_wreg;

    logic w_in_wait, w_accept, w_in_mem, w_done_wait, w_complete;
    assign w_in_wait   = (r_state == c_ST_WAIT);
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_in_mem    = mem_read | mem_write;
    assign w_done_wait = w_in_wait & ~flush & (r_cnt == c_WS);
    assign w_complete  = (~w_in_wait & w_accept & (~w_in_mem | (c_WS == 3'd0))) | w_done_wait;

    // In WAIT the operation comes from the captured bundle, otherwise straight from upstream.
    logic        w_rd, w_wr, w_sgn, w_regwr;
    logic [1:0]  w_size, w_memto;
    logic [31:0] w_addr, w_wdata, w_pc4;
    logic [4:0]  w_wreg;
    assign w_rd    = w_in_wait ? r_op_read   : mem_read;
    assign w_wr    = w_in_wait ? r_op_write  : mem_write;
    assign w_sgn   = w_in_wait ? r_op_signed : mem_signed;
    assign w_regwr = w_in_wait ? r_op_regwr  : reg_write;
    assign w_size  = w_in_wait ? r_op_size   : mem_size;
    assign w_memto = w_in_wait ? r_op_memto  : memto_reg;
    assign w_addr  = w_in_wait ? r_op_addr   : alu_result;
    assign w_wdata = w_in_wait ? r_op_wdata  : write_data;
    assign w_pc4   = w_in_wait ? r_op_pc4    : pc_plus4;
    assign w_wreg  = w_in_wait ? r_op_wreg   : write_reg;

    logic                  w_oor, w_mis, w_mis_op, w_is_load, w_mem_we;
    logic [DEPTH_LOG2-1:0] w_idx;
    assign w_oor     = |w_addr[31:DEPTH_LOG2+2];
    assign w_idx     = w_addr[DEPTH_LOG2+1:2];
    assign w_is_load = w_rd & ~w_wr;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_mis     = ((w_size == 2'b01) & w_addr[0]) | (w_size[1] & (|w_addr[1:0]));
`else
    assign w_mis     = 1'b0;
`endif
    assign w_mis_op  = w_mis & (w_rd | w_wr);
    assign w_mem_we  = w_complete & ~reset & w_wr & ~w_oor & ~w_mis_op;

    logic [31:0] w_word, w_ext, w_lanes;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;
    assign w_word = w_oor ? 32'd0 : r_mem[w_idx];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_ext   = w_word;
        w_lanes = w_wdata;
        w_be    = 4'b1111;
        case (w_size)
            2'b00: begin
                w_ext   = {{24{w_sgn & w_byte[7]}}, w_byte};
                w_lanes = {4{w_wdata[7:0]}};
                w_be    = 4'b0001 << w_addr[1:0];
            end
            2'b01: begin
                w_ext   = {{16{w_sgn & w_half[15]}}, w_half};
                w_lanes = {2{w_wdata[15:0]}};
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Data memory deliberately has no reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_read   <= mem_read;
            r_op_write  <= mem_write;
            r_op_signed <= mem_signed;
            r_op_regwr  <= reg_write;
            r_op_size   <= mem_size;
            r_op_memto  <= memto_reg;
            r_op_addr   <= alu_result;
            r_op_wdata  <= write_data;
            r_op_pc4    <= pc_plus4;
            r_op_wreg   <= write_reg;
        end
    end

    // FSM: state register, next-state logic, outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_wait) r_cnt <= (w_done_wait | flush) ? 3'd0 : r_cnt + 3'd1;
            else if (w_state_nxt == c_ST_WAIT) r_cnt <= 3'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept & w_in_mem & (c_WS != 3'd0)) w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (flush | (r_cnt == c_WS)) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == c_ST_IDLE) & (~wb_valid | wb_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_alu_result <= 32'd0;
            wb_read_data  <= 32'd0;
            wb_pc_plus4   <= 32'd0;
            wb_memto_reg  <= 2'd0;
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= 5'd0;
        end else if (w_complete) begin
            wb_valid      <= 1'b1;
            wb_alu_result <= w_addr;
            wb_read_data  <= (w_is_load & ~w_mis_op) ? w_ext : 32'd0;
            wb_pc_plus4   <= w_pc4;
            wb_memto_reg  <= w_memto;
            wb_reg_write  <= w_regwr & ~w_mis_op;
            wb_write_reg  <= w_wreg;
        end else if (wb_ready) begin
            wb_valid      <= 1'b0;
        end
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= w_complete & w_mis_op;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ws.sv
// ============================================================================
// Module   : tb_mem_stage_ws
// Brief    : Directed self-checking bench for mem_stage_ws (WAIT_STATES=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ws;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, mem_read, mem_write, mem_signed;
    logic [1:0]  mem_size, memto_reg, wb_memto_reg;
    logic [31:0] alu_result, write_data, pc_plus4;
    logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus4;
    logic        reg_write, flush, wb_valid, wb_ready, wb_reg_write;
    logic [4:0]  write_reg, wb_write_reg;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ws #(.DEPTH_LOG2(8), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_signed(mem_signed), .alu_result(alu_result), .write_data(write_data),
        .pc_plus4(pc_plus4), .memto_reg(memto_reg), .reg_write(reg_write),
        .write_reg(write_reg), .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
        .wb_pc_plus4(wb_pc_plus4), .wb_memto_reg(wb_memto_reg),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd);
        mem_read   = rd;
        mem_write  = wr;
        mem_size   = sz;
        mem_signed = sg;
        alu_result = addr;
        write_data = wd;
        pc_plus4   = addr + 32'd4;
        memto_reg  = rd ? 2'b01 : 2'b00;
        reg_write  = ~wr;
        write_reg  = 5'd9;
    endtask

    task automatic accept_op();
        bit ok = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b expected 0", wb_valid); end
        n_checks++; if ({wb_alu_result, wb_read_data, wb_pc_plus4} !== 96'd0)
            begin n_fail++; $display("FAIL rst_wb_data: got %h %h %h expected zeros", wb_alu_result, wb_read_data, wb_pc_plus4); end
        n_checks++; if ({wb_reg_write, wb_write_reg, wb_memto_reg} !== 8'd0)
            begin n_fail++; $display("FAIL rst_wb_ctrl: got %b %h %b expected zeros", wb_reg_write, wb_write_reg, wb_memto_reg); end
    endtask

    task automatic test_store_load_word();
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        accept_op();
        n_checks++; if ({in_ready, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL st_wait: ready/valid got %b expected 00", {in_ready, wb_valid}); end
        tick();
        n_checks++; if ({wb_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL st_done: valid/ready got %b expected 11", {wb_valid, in_ready}); end
        n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL st_rdata: got %h expected 0", wb_read_data); end
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        accept_op();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_early: wb_valid got %b expected 0", wb_valid); end
        tick();
        n_checks++; if (wb_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word: got %h expected deadbeef", wb_read_data); end
        n_checks++; if ({wb_alu_result, wb_pc_plus4} !== {32'h10, 32'h14}) begin n_fail++; $display("FAIL ld_pass: got %h %h expected 10 14", wb_alu_result, wb_pc_plus4); end
        n_checks++; if ({wb_reg_write, wb_memto_reg, wb_write_reg} !== {1'b1, 2'b01, 5'd9})
            begin n_fail++; $display("FAIL ld_ctrl: got %b %b %h expected 1 01 09", wb_reg_write, wb_memto_reg, wb_write_reg); end
        set_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h0F0F0F0F);
        accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL rdwr_rdata: got %h expected 0", wb_read_data); end
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL rdwr_store: got %h expected 0f0f0f0f", wb_read_data); end
    endtask

    task automatic test_byte_lanes();
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);        accept_op(); tick();
        set_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080); accept_op(); tick();
        set_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);        accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed: got %h expected ffffff80", wb_read_data); end
        set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);        accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h00000080) begin n_fail++; $display("FAIL lb_unsigned: got %h expected 00000080", wb_read_data); end
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);        accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h80000000) begin n_fail++; $display("FAIL lw_after_sb: got %h expected 80000000", wb_read_data); end
        set_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);        accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'hFFFF8000) begin n_fail++; $display("FAIL lh_signed: got %h expected ffff8000", wb_read_data); end
        set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);        accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL lh_low: got %h expected 0", wb_read_data); end
    endtask

    task automatic test_backpressure();
        set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'hAAAA5555, 32'h0);
        accept_op();
        wb_ready = 1'b0;
        n_checks++; if ({wb_valid, wb_alu_result, wb_pc_plus4} !== {1'b1, 32'hAAAA5555, 32'hAAAA5559})
            begin n_fail++; $display("FAIL alu_1cyc: got %b %h %h expected 1 aaaa5555 aaaa5559", wb_valid, wb_alu_result, wb_pc_plus4); end
        set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h11111111, 32'h0);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({wb_valid, in_ready, wb_alu_result} !== {1'b1, 1'b0, 32'hAAAA5555})
                begin n_fail++; $display("FAIL stall_%0d: valid/ready/alu got %b %b %h expected 1 0 aaaa5555", c, wb_valid, in_ready, wb_alu_result); end
        end
        wb_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if ({wb_valid, wb_alu_result} !== {1'b1, 32'h11111111})
            begin n_fail++; $display("FAIL b2b: got %b %h expected 1 11111111", wb_valid, wb_alu_result); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL drain: wb_valid got %b expected 0", wb_valid); end
    endtask

    task automatic test_flush();
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A0000); accept_op(); tick();
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h00001234); accept_op();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if ({wb_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_abort: valid/ready got %b expected 01", {wb_valid, in_ready}); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_late: wb_valid got %b expected 0", wb_valid); end
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0); accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h5A5A0000) begin n_fail++; $display("FAIL flush_mem: got %h expected 5a5a0000", wb_read_data); end
    endtask

    task automatic test_out_of_range();
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h01020304);       accept_op(); tick();
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h00010000, 32'hFFFFFFFF); accept_op(); tick();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h00010000, 32'h0);        accept_op(); tick();
        n_checks++; if ({wb_valid, wb_read_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL oor_load: got %b %h expected 1 0", wb_valid, wb_read_data); end
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);               accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h01020304) begin n_fail++; $display("FAIL oor_store: got %h expected 01020304", wb_read_data); end
    endtask

    task automatic test_reset_wait();
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
        accept_op();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({wb_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_wait: valid/ready got %b expected 01", {wb_valid, in_ready}); end
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0); accept_op(); tick();
        n_checks++; if (wb_read_data !== 32'h80000000) begin n_fail++; $display("FAIL rst_mem_kept: got %h expected 80000000", wb_read_data); end
    endtask

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    task automatic test_misalign();
        set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0); accept_op(); tick();
        n_checks++; if ({misalign, wb_valid, wb_reg_write} !== 3'b110)
            begin n_fail++; $display("FAIL mis_pulse: mis/valid/regw got %b expected 110", {misalign, wb_valid, wb_reg_write}); end
        n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h expected 0", wb_read_data); end
        tick();
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_width: got %b expected 0", misalign); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load_word();
        test_byte_lanes();
        test_backpressure();
        test_flush();
        test_out_of_range();
        test_reset_wait();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
